// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
//   bcd_digit_t : one 4-bit BCD digit
//   state_t     : sequencer states IDLE / ADD / DONE
//   BCD_MAX     : largest valid decimal digit
//   BCD_ADJ     : decimal adjust added when a digit sum exceeds BCD_MAX
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adder.sv
// Single-digit decimal adder (combinational).
//   a_d, b_d : operand digits (values above 9 are accepted and follow the
//              same formula; the result is then not valid BCD)
//   c_in     : decimal carry in
//   s_d      : result digit
//   c_out    : decimal carry out
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out
);

  logic [4:0] s5;
  logic [4:0] adj;

  // 5-bit binary sum, then decimal adjust when it passes 9
  always_comb begin
    s5  = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
    adj = s5 + {1'b0, BCD_ADJ};
    if (s5 > {1'b0, BCD_MAX}) begin
      s_d   = adj[3:0];
      c_out = 1'b1;
    end else begin
      s_d   = s5[3:0];
      c_out = 1'b0;
    end
  end

endmodule : bcd_digit_adder

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD addition sequencer. Captures two DIGITS-wide
// operands on start, walks one shared bcd_digit_adder from digit 0 upward,
// one digit per clock, and reports the sum with a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   a, b, cin  : packed BCD operands (digit 0 = bits [3:0]) and carry in
//   busy       : operation in progress
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : packed BCD result and decimal carry out of the top digit
//   err        : an operand digit above 9 was seen
// Optional feature: define BCD_ERR_CHECK_EN to build the invalid-digit
// check; otherwise err is tied low.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               accept;
  logic               step;
  logic               finish;
  logic               busy_d;
  logic               done_d;
  bcd_digit_t         a_d;
  bcd_digit_t         b_d;
  bcd_digit_t         s_d;
  logic               c_out;
  logic [W-1:0]       sum_nxt;

  assign last = (idx == IDX_W'(DIGITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes and next values of the registered status outputs
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state_q)
      IDLE:    accept = start;
      ADD: begin
        step   = 1'b1;
        finish = last;
      end
      default: ;
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // Select the current digit pair and merge the result digit into sum
  always_comb begin
    a_d     = '0;
    b_d     = '0;
    sum_nxt = sum;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        a_d                = op_a[4*i +: 4];
        b_d                = op_b[4*i +: 4];
        sum_nxt[4*i +: 4]  = s_d;
      end
    end
  end

  bcd_digit_adder u_digit_adder (
    .a_d   (a_d),
    .b_d   (b_d),
    .c_in  (carry),
    .s_d   (s_d),
    .c_out (c_out)
  );

  // Status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand capture, digit ripple and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      idx   <= '0;
      sum   <= '0;
    end else if (step) begin
      sum   <= sum_nxt;
      carry <= c_out;
      idx   <= finish ? '0 : idx + IDX_W'(1);
      if (finish) cout <= c_out;
    end
  end

`ifdef BCD_ERR_CHECK_EN
  logic err_acc;
  logic err_q;
  logic bad_now;

  assign bad_now = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  assign err     = err_q;

  // Sticky invalid-digit flag; published on entry to DONE, cleared on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else if (step) begin
      err_acc <= err_acc | bad_now;
      if (finish) err_q <= err_acc | bad_now;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule : bcd_serial_add_ctrl

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Digit-serial sequencer for a multi-digit packed-BCD addition. It captures two DIGITS-wide BCD operands on a start handshake and drives one shared single-digit BCD adder datapath, least-significant digit first, one digit per clock. The decimal carry is rippled through a register. It returns the packed sum and decimal carry-out with a one-cycle done pulse, and sits between a control master and the single-digit BCD adder resource.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  packed BCD operand A; digit 0 = bits [3:0]
- b  in  4*DIGITS  packed BCD operand B
- cin  in  1  decimal carry-in to digit 0
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; sum/cout valid
- sum  out  4*DIGITS  packed BCD result; held until the next accepted start
- cout  out  1  decimal carry out of the top digit
- err  out  1  an operand digit > 9 was seen (see Configuration)

## Operation
- States: IDLE, ADD, DONE.
  - IDLE → ADD when start=1. Capture a, b and cin into operand registers, clear digit index idx, and clear sum.
  - ADD: present digit idx of A, digit idx of B and the carry register to the datapath. Write the result digit into sum[4*idx +: 4], update the carry register, and increment idx. When idx = DIGITS-1, go to DONE.
  - DONE: done=1 and cout = carry register. Go to IDLE unconditionally.
- Digit arithmetic: s = a_d + b_d + c, computed as a 5-bit sum.
  - If s > 9: digit = (s + 6)[3:0] and carry = 1.
  - Otherwise: digit = s[3:0] and carry = 0.
- Digits greater than 9 use the same formula, so the result is defined but not a valid BCD number.
- start is ignored in ADD and DONE. No queueing. Inputs a, b and cin may change freely after they are captured.
- Reset (asynchronous, any state) clears the following:
  - state = IDLE, busy = 0, done = 0
  - sum = 0, cout = 0, err = 0
  - idx, the carry register and the operand registers
- An operation in flight when reset asserts is lost. No done pulse is issued for it.

## Timing
- Start sampled high at edge T0. busy=1 from T0 through the edge T0+DIGITS.
- done=1 for exactly one cycle, in the cycle following edge T0+DIGITS. Latency from start to done is DIGITS+1 cycles.
- busy=0 when done=1. The earliest next accepted start is the edge that ends the DONE cycle plus one, so throughput is one operation per DIGITS+2 cycles.
- sum digits update progressively during ADD. Consumers use them only when done=1 or afterwards.
- cout changes only on entry to DONE. err changes only on start acceptance and on entry to DONE.

## Configuration
- BCD_ERR_CHECK_EN defined:
  - Each ADD cycle checks a_d > 9 and b_d > 9, accumulating into a sticky flag.
  - err is set on entry to DONE if any digit was invalid.
  - err is cleared on the next accepted start.
  - The computation is unaffected.
- BCD_ERR_CHECK_EN undefined: no check logic is built and err is tied to 0.

## Structure
- Shared package bcd_pkg holds:
  - the bcd_digit_t typedef (4-bit)
  - the state enum (IDLE, ADD, DONE)
  - constants BCD_MAX = 9 and BCD_ADJ = 6
- One combinational sub-module, bcd_digit_adder (ports: a_d, b_d, c_in → s_d, c_out), implements the digit arithmetic above. It is instantiated exactly once in the controller.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, one-cycle start → sum=0x6912, cout=0, done exactly 5 cycles after the start edge, busy high 4 cycles.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- Start held high for 10 cycles with a change of a mid-operation → exactly one operation using the values captured at acceptance, then a second operation accepted in IDLE. Sum held between operations.
- Assert rst_n=0 asynchronously during the second ADD cycle → all outputs 0 immediately, state IDLE, no done pulse. A fresh start after release gives a correct result.
- With BCD_ERR_CHECK_EN, a=0x00A0, b=0x0001 → err=1 at done, and sum follows the formula: digit 1 = (10+0+0+6)[3:0] = 0 with carry 1, giving sum=0x0101. A valid next operation clears err. Without the macro, err stays 0.
